// File: rtl/ram512x8_mem.sv
// ram512x8_mem
// Byte-addressed 512 x 8 synchronous memory shared by instruction fetch and
// MIPS load/store data accesses of the multicycle datapath. A request is
// presented with MOV and acknowledged with MOC; DMOC additionally marks
// completion of load/store opcodes. Multi-byte accesses are big-endian and
// wrap modulo 512.
//
// Parameters:
//   LATENCY  clock cycles from MOV acceptance to completion (1..15)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   DataOut  out  32-bit registered read data
//   MOC      out  memory operation complete
//   DMOC     out  data-access (load/store opcode) complete
//   RW       in   1 = read, 0 = write
//   MOV      in   memory operation valid (request)
//   Address  in   9-bit byte address
//   DataIn   in   32-bit write data
//   OpC      in   6-bit MIPS opcode selecting size/extension
//
// Optional build macro:
//   RAM_ALIGN_CHECK_EN  force word accesses to Address[1:0]=0 and halfword
//                       accesses to Address[0]=0; byte accesses unaffected.

module ram512x8_mem #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        DMOC,
    input  logic        RW,
    input  logic        MOV,
    input  logic [8:0]  Address,
    input  logic [31:0] DataIn,
    input  logic [5:0]  OpC
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        rw_q;
    logic [8:0]  addr_q;
    logic [5:0]  opc_q;
    logic [31:0] din_q;

    logic [7:0]  Mem [0:511];

    logic        accept, complete;
    logic        is_byte, is_half, is_data_op;
    logic [8:0]  eff_addr, addr_p1, addr_p2, addr_p3;
    logic [31:0] rd_word, rd_data;

    // Next-state logic: accept from IDLE, finish when the countdown hits
    // zero, and leave DONE only once the requester drops MOV.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (MOV) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    complete   = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!MOV) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Access size comes from the latched opcode; the same opcode means
    // different sizes for reads and writes, so RW picks the table.
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        if (rw_q) begin
            is_byte = (opc_q == OP_LB) || (opc_q == OP_LBU);
            is_half = (opc_q == OP_LH) || (opc_q == OP_LHU);
        end else begin
            is_byte = (opc_q == OP_SB);
            is_half = (opc_q == OP_SH);
        end
    end

    // DMOC only accompanies genuine load/store opcodes, whatever RW says.
    always_comb begin
        case (opc_q)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW:
                is_data_op = 1'b1;
            default:
                is_data_op = 1'b0;
        endcase
    end

    // Effective address, optionally aligned to the access size. The +1..+3
    // byte addresses wrap naturally in 9 bits.
    always_comb begin
        eff_addr = addr_q;
`ifdef RAM_ALIGN_CHECK_EN
        if (is_half)
            eff_addr[0] = 1'b0;
        else if (!is_byte)
            eff_addr[1:0] = 2'b00;
`endif
        addr_p1 = eff_addr + 9'd1;
        addr_p2 = eff_addr + 9'd2;
        addr_p3 = eff_addr + 9'd3;
    end

    // Big-endian word assembly and load extension.
    always_comb begin
        rd_word = {Mem[eff_addr], Mem[addr_p1], Mem[addr_p2], Mem[addr_p3]};
        case (opc_q)
            OP_LB:   rd_data = {{24{rd_word[31]}}, rd_word[31:24]};
            OP_LBU:  rd_data = {24'h0, rd_word[31:24]};
            OP_LH:   rd_data = {{16{rd_word[31]}}, rd_word[31:16]};
            OP_LHU:  rd_data = {16'h0, rd_word[31:16]};
            default: rd_data = rd_word;
        endcase
    end

    // Control and handshake registers. Request fields are captured on
    // acceptance so later input changes cannot disturb the access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rw_q    <= 1'b0;
            addr_q  <= 9'd0;
            opc_q   <= 6'd0;
            din_q   <= 32'd0;
            MOC     <= 1'b0;
            DMOC    <= 1'b0;
            DataOut <= 32'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                rw_q   <= RW;
                addr_q <= Address;
                opc_q  <= OpC;
                din_q  <= DataIn;
                cnt    <= CNT_INIT;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (complete) begin
                MOC  <= 1'b1;
                DMOC <= is_data_op;
                if (rw_q) DataOut <= rd_data;
            end else if (state == DONE && !MOV) begin
                MOC  <= 1'b0;
                DMOC <= 1'b0;
            end
        end
    end

    // Storage is never reset. A write commits only on the completion edge,
    // so a reset during BUSY leaves the array untouched.
    always_ff @(posedge clk) begin
        if (complete && !rw_q) begin
            if (is_byte) begin
                Mem[eff_addr] <= din_q[7:0];
            end else if (is_half) begin
                Mem[eff_addr] <= din_q[15:8];
                Mem[addr_p1]  <= din_q[7:0];
            end else begin
                Mem[eff_addr] <= din_q[31:24];
                Mem[addr_p1]  <= din_q[23:16];
                Mem[addr_p2]  <= din_q[15:8];
                Mem[addr_p3]  <= din_q[7:0];
            end
        end
    end

endmodule

// File: tb/tb_ram512x8_mem.sv
// tb_ram512x8_mem
// Directed bench for ram512x8_mem. One instance uses the default LATENCY=1,
// a second uses LATENCY=4 for the multi-cycle and reset-abort sequences.

module tb_ram512x8_mem;

    typedef struct packed {
        logic        rw;
        logic [5:0]  opc;
        logic [8:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_data;
        logic        exp_dmoc;
    } vec_t;

    localparam int NV = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rw, mov;
    logic [8:0]  address;
    logic [31:0] data_in;
    logic [5:0]  opc;
    logic [31:0] data_out;
    logic        moc, dmoc;

    logic        s_reset;
    logic        s_rw, s_mov;
    logic [8:0]  s_address;
    logic [31:0] s_data_in;
    logic [5:0]  s_opc;
    logic [31:0] s_data_out;
    logic        s_moc, s_dmoc;

    int vectors = 0;
    int miscompares = 0;

    vec_t vecs [NV];

    ram512x8_mem #(.LATENCY(1)) dut (
        .clk(clk), .reset(reset), .DataOut(data_out), .MOC(moc), .DMOC(dmoc),
        .RW(rw), .MOV(mov), .Address(address), .DataIn(data_in), .OpC(opc)
    );

    ram512x8_mem #(.LATENCY(4)) dut_slow (
        .clk(clk), .reset(s_reset), .DataOut(s_data_out), .MOC(s_moc), .DMOC(s_dmoc),
        .RW(s_rw), .MOV(s_mov), .Address(s_address), .DataIn(s_data_in), .OpC(s_opc)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One full handshake on the LATENCY=1 instance, starting and ending at a
    // falling edge. Inputs are scrambled after acceptance to prove latching.
    task automatic applyStimulus(input logic r, input logic [8:0] a, input logic [5:0] o,
                                 input logic [31:0] d, input logic [31:0] exp_data,
                                 input logic exp_dmoc, input string name);
        rw = r; address = a; opc = o; data_in = d; mov = 1'b1;
        @(negedge clk);
        checkOutput({name, " moc_accept"}, {31'b0, moc}, 32'd0);
        rw = ~r; address = ~a; opc = 6'h3F; data_in = ~d;
        @(negedge clk);
        checkOutput({name, " moc_done"}, {31'b0, moc}, 32'd1);
        checkOutput({name, " dmoc_done"}, {31'b0, dmoc}, {31'b0, exp_dmoc});
        checkOutput({name, " data"}, data_out, exp_data);
        mov = 1'b0;
        @(negedge clk);
        checkOutput({name, " moc_clear"}, {31'b0, moc}, 32'd0);
        checkOutput({name, " dmoc_clear"}, {31'b0, dmoc}, 32'd0);
        checkOutput({name, " data_hold"}, data_out, exp_data);
    endtask

    // Same handshake on the LATENCY=4 instance, checking MOC stays low for
    // exactly four edges after acceptance.
    task automatic applyStimulusSlow(input logic r, input logic [8:0] a, input logic [5:0] o,
                                     input logic [31:0] d, input logic [31:0] exp_data,
                                     input logic exp_dmoc, input string name);
        s_rw = r; s_address = a; s_opc = o; s_data_in = d; s_mov = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s moc_wait%0d", name, k), {31'b0, s_moc}, 32'd0);
        end
        @(negedge clk);
        checkOutput({name, " moc_done"}, {31'b0, s_moc}, 32'd1);
        checkOutput({name, " dmoc_done"}, {31'b0, s_dmoc}, {31'b0, exp_dmoc});
        checkOutput({name, " data"}, s_data_out, exp_data);
        s_mov = 1'b0;
        @(negedge clk);
        checkOutput({name, " moc_clear"}, {31'b0, s_moc}, 32'd0);
    endtask

    initial begin
        int highs;

        vecs[0]  = '{1'b1, 6'h00, 9'd0,  32'h0,        32'h12345678, 1'b0};
        vecs[1]  = '{1'b1, 6'h20, 9'd8,  32'h0,        32'hFFFFFF80, 1'b1};
        vecs[2]  = '{1'b1, 6'h24, 9'd8,  32'h0,        32'h00000080, 1'b1};
        vecs[3]  = '{1'b1, 6'h21, 9'd8,  32'h0,        32'hFFFF8001, 1'b1};
        vecs[4]  = '{1'b1, 6'h25, 9'd8,  32'h0,        32'h00008001, 1'b1};
        vecs[5]  = '{1'b0, 6'h2B, 9'd16, 32'hDEADBEEF, 32'h00008001, 1'b1};
        vecs[6]  = '{1'b1, 6'h23, 9'd16, 32'h0,        32'hDEADBEEF, 1'b1};
        vecs[7]  = '{1'b0, 6'h28, 9'd17, 32'h000000AA, 32'hDEADBEEF, 1'b1};
        vecs[8]  = '{1'b1, 6'h23, 9'd16, 32'h0,        32'hDEAABEEF, 1'b1};
        vecs[9]  = '{1'b0, 6'h29, 9'd18, 32'h1234CAFE, 32'hDEAABEEF, 1'b1};
        vecs[10] = '{1'b1, 6'h23, 9'd16, 32'h0,        32'hDEAACAFE, 1'b1};
        vecs[11] = '{1'b0, 6'h3F, 9'd24, 32'h01020304, 32'hDEAACAFE, 1'b0};
        vecs[12] = '{1'b1, 6'h00, 9'd24, 32'h0,        32'h01020304, 1'b0};
        vecs[13] = '{1'b1, 6'h20, 9'd27, 32'h0,        32'h00000004, 1'b1};
        vecs[14] = '{1'b1, 6'h21, 9'd26, 32'h0,        32'h00000304, 1'b1};
        vecs[15] = '{1'b1, 6'h2B, 9'd0,  32'h0,        32'h12345678, 1'b1};
        vecs[16] = '{1'b1, 6'h28, 9'd8,  32'h0,        32'h80017F00, 1'b1};

        reset = 1'b1; rw = 1'b1; mov = 1'b0; address = '0; data_in = '0; opc = '0;
        s_reset = 1'b1; s_rw = 1'b1; s_mov = 1'b0; s_address = '0; s_data_in = '0; s_opc = '0;
        @(negedge clk);
        checkOutput("reset moc", {31'b0, moc}, 32'd0);
        checkOutput("reset dmoc", {31'b0, dmoc}, 32'd0);
        checkOutput("reset data", data_out, 32'd0);
        checkOutput("reset slow data", s_data_out, 32'd0);

        dut.Mem[0]  <= 8'h12; dut.Mem[1]  <= 8'h34;
        dut.Mem[2]  <= 8'h56; dut.Mem[3]  <= 8'h78;
        dut.Mem[8]  <= 8'h80; dut.Mem[9]  <= 8'h01;
        dut.Mem[10] <= 8'h7F; dut.Mem[11] <= 8'h00;
        dut_slow.Mem[20] <= 8'h11; dut_slow.Mem[21] <= 8'h22;
        dut_slow.Mem[22] <= 8'h33; dut_slow.Mem[23] <= 8'h44;
        reset = 1'b0; s_reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++)
            applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].opc, vecs[i].din,
                          vecs[i].exp_data, vecs[i].exp_dmoc, $sformatf("vec%0d", i));

        // Wrapping fetch and unaligned halfword.
        dut.Mem[508] <= 8'hAA; dut.Mem[509] <= 8'hBB;
        dut.Mem[510] <= 8'h01; dut.Mem[511] <= 8'h02;
        dut.Mem[0]   <= 8'h03; dut.Mem[1]   <= 8'h04;
        @(negedge clk);
`ifdef RAM_ALIGN_CHECK_EN
        applyStimulus(1'b1, 9'd510, 6'h00, 32'h0, 32'hAABB0102, 1'b0, "wrap_fetch");
        applyStimulus(1'b1, 9'd9,   6'h21, 32'h0, 32'hFFFF8001, 1'b1, "lh_unaligned");
`else
        applyStimulus(1'b1, 9'd510, 6'h00, 32'h0, 32'h01020304, 1'b0, "wrap_fetch");
        applyStimulus(1'b1, 9'd9,   6'h21, 32'h0, 32'h0000017F, 1'b1, "lh_unaligned");
`endif

        // MOV held after completion: no second access.
        rw = 1'b1; opc = 6'h23; address = 9'd16; mov = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("held first data", data_out, 32'hDEAACAFE);
        address = 9'd0; opc = 6'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("held moc%0d", k), {31'b0, moc}, 32'd1);
            checkOutput($sformatf("held data%0d", k), data_out, 32'hDEAACAFE);
        end
        mov = 1'b0;
        @(negedge clk);
        checkOutput("held release moc", {31'b0, moc}, 32'd0);
        applyStimulus(1'b1, 9'd0, 6'h00, 32'h0, 32'h03045678, 1'b0, "after_gap");

        // LATENCY=4: plain load.
        applyStimulusSlow(1'b1, 9'd20, 6'h23, 32'h0, 32'h11223344, 1'b1, "slow_lw");

        // LATENCY=4: MOV dropped during BUSY gives a one-cycle MOC.
        s_rw = 1'b1; s_opc = 6'h24; s_address = 9'd21; s_mov = 1'b1;
        @(negedge clk);
        s_mov = 1'b0;
        highs = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (s_moc) highs++;
            if (k == 4) checkOutput("drop moc_at_done", {31'b0, s_moc}, 32'd1);
        end
        checkOutput("drop moc_cycles", highs, 32'd1);
        checkOutput("drop data", s_data_out, 32'h00000022);

        // LATENCY=4: reset during the second BUSY cycle of a store.
        s_rw = 1'b0; s_opc = 6'h2B; s_address = 9'd20; s_data_in = 32'hDEADBEEF; s_mov = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s_reset = 1'b1;
        #1;
        checkOutput("abort moc", {31'b0, s_moc}, 32'd0);
        checkOutput("abort dmoc", {31'b0, s_dmoc}, 32'd0);
        checkOutput("abort data", s_data_out, 32'd0);
        s_mov = 1'b0;
        @(negedge clk);
        s_reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("abort mem", {dut_slow.Mem[20], dut_slow.Mem[21],
                                  dut_slow.Mem[22], dut_slow.Mem[23]}, 32'h11223344);
        checkOutput("abort idle moc", {31'b0, s_moc}, 32'd0);
        applyStimulusSlow(1'b1, 9'd20, 6'h23, 32'h0, 32'h11223344, 1'b1, "slow_after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
